matrix_scan_ctrl: RTL and testbench
===================================

Name: matrix_scan_ctrl

Overview:
- Scan/BCM scheduler for the badge's HUB75-style 32xN RGB panel: two half-panels, 4-bit row address, serial shift clock, latch and output-enable.
- Fetches pixel words from the framebuffer over a 1-cycle-latency read port and shifts one bit-plane per pass.
- Sequences latch, row address and blanking, and holds each plane on for a binary-weighted time.
- Sits between the framebuffer RAM and the panel pins and replaces free-running pin toggling with a deterministic frame schedule.

Parameters:
- COLS, 32, columns per row shifted per plane (power of 2, >=2)
- ROW_BITS, 4, row address width; rows per half-panel = 2**ROW_BITS
- BITS, 4, colour depth per channel = number of bit-planes
- BASE_TIME, 8, display cycles for plane 0 (>=1); plane p displays BASE_TIME<<p cycles

Ports:
- clk  in  1  system clock; only clock
- rst  in  1  reset, asynchronous assert, active-low (0 = reset)
- enable  in  1  run scan when 1
- fb_rd_en  out  1  framebuffer read strobe
- fb_addr  out  ROW_BITS+log2(COLS)  {row, col}
- fb_data  in  6*BITS  valid the cycle after fb_rd_en. Lane k = fb_data[BITS*k +: BITS], k: 0=r0, 1=g0, 2=b0, 3=r1, 4=g1, 5=b1
- mat_r, mat_g, mat_b  out  2 each  bit [0] = upper half, [1] = lower half; current plane bit of the lane
- mat_row  out  ROW_BITS  displayed row address
- mat_clk  out  1  shift clock
- mat_lat  out  1  latch, active-high
- mat_oe  out  1  output enable, active-low (1 = blanked)
- frame_start  out  1  1-cycle pulse at start of each frame (row 0, plane 0)

Behaviour:
- Reset (rst=0, async):
  - State IDLE; all counters 0.
  - mat_r/g/b=0, mat_row=0, mat_clk=0, mat_lat=0, mat_oe=1, fb_rd_en=0, fb_addr=0, frame_start=0.
  - Reset mid-operation aborts immediately to these values; the first pass after release begins at row 0, plane 0.
- All outputs are registered.
- Loop order: for row 0..2**ROW_BITS-1, for plane 0..BITS-1. Row wraps from max to 0 and begins a new frame.
- States per plane pass:
  - IDLE: mat_oe=1. Leave to PREF0 when enable=1.
  - PREF0 (1 cycle): fb_rd_en=1, fb_addr={row,0}. frame_start=1 if row=0 and plane=0.
  - PREF1 (1 cycle): capture fb_data plane bit into the data registers.
  - SHIFT (2*COLS cycles), two cycles per column c:
    - D cycle: new data visible, mat_clk=0. If c<COLS-1, fb_rd_en=1 and fb_addr={row,c+1}.
    - H cycle: mat_clk=1, data held. Data registers load from fb_data at the end of H.
  - BLANK (1 cycle): mat_clk=0, mat_oe=1.
  - LATCH (1 cycle): mat_lat=1, mat_row<=row, mat_oe=1.
  - DISPLAY (BASE_TIME<<plane cycles): mat_oe=0, mat_lat=0. Then advance plane/row and go to PREF0, or to IDLE if enable=0.
- mat_oe=1 in every state except DISPLAY. Row address never changes while mat_oe=0.
- Plane pass length = 2*COLS + 4 + (BASE_TIME<<plane) cycles.
- mat_r[0] = fb_data lane r0 bit [plane]; the other lanes map the same way.
- enable is sampled only in IDLE and at DISPLAY end. Dropping it mid-pass completes the current plane, then parks in IDLE blanked with counters held. Re-enabling resumes at the next row/plane.
- fb_rd_en is asserted exactly COLS times per pass. fb_addr holds its last value when not reading.
- Counter widths: column counter log2(COLS)+1 bits, display counter sized for BASE_TIME<<(BITS-1). No overflow permitted at maximum parameters.

Decomposition:
- Shared package matrix_pkg:
  - state enum (IDLE, PREF0, PREF1, SHIFT, BLANK, LATCH, DISPLAY)
  - lane index constants LANE_R0..LANE_B1
  - fb address width function
- One natural sub-module, matrix_bcm_timer: loads BASE_TIME<<plane on start and pulses done at expiry. Reused for global brightness later.

Test Plan (COLS=4, ROW_BITS=4, BITS=2, BASE_TIME=2 unless stated):
- Reset/idle: rst=0 then release with enable=0 -> mat_oe=1, mat_lat=0, mat_clk=0, fb_rd_en=0, mat_row=0 held for 100 cycles.
- Single pass timing: enable=1 -> frame_start on first PREF0; plane0 pass = 14 cycles and plane1 = 16 cycles; 4 mat_clk rising edges per pass; mat_lat high exactly 1 cycle per pass; frame = 480 cycles between frame_start pulses.
- Data mapping: fb model returns lane r0=2'b01 and b1=2'b10 for col 2, other lanes 0 -> plane0 pass: mat_r[0]=1 during col 2 D/H; plane1 pass: mat_b[1]=1 during col 2. fb_addr sequence {row,0..3} with one-cycle read latency honoured.
- Blanking/ghosting: assertion over a full frame that mat_row changes only when mat_oe=1, and mat_oe=0 exactly 2 cycles (plane0) or 4 cycles (plane1) per pass.
- Enable drop: deassert enable mid-SHIFT of row 5, plane 0 -> pass completes, IDLE with mat_oe=1; re-enable -> next PREF0 targets row 5, plane 1.
- Async reset mid-DISPLAY: rst=0 without clock edge -> mat_oe=1 and mat_row=0 immediately; restart at row 0, plane 0 with frame_start.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared definitions for the HUB75 matrix scan controller: FSM encodings,
// framebuffer lane indices and width helpers.
package matrix_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PREF0   = 3'd1;
    localparam logic [2:0] S_PREF1   = 3'd2;
    localparam logic [2:0] S_SHIFT   = 3'd3;
    localparam logic [2:0] S_BLANK   = 3'd4;
    localparam logic [2:0] S_LATCH   = 3'd5;
    localparam logic [2:0] S_DISPLAY = 3'd6;

    localparam int LANE_R0   = 0;
    localparam int LANE_G0   = 1;
    localparam int LANE_B0   = 2;
    localparam int LANE_R1   = 3;
    localparam int LANE_G1   = 4;
    localparam int LANE_B1   = 5;
    localparam int NUM_LANES = 6;

    function automatic int fb_addr_w(input int row_bits, input int cols);
        return row_bits + $clog2(cols);
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matrix_bcm_timer.sv
// Binary-coded-modulation on-time timer: loads BASE_TIME<<plane on start
// and raises done during the final cycle of the interval.
module matrix_bcm_timer
    import matrix_pkg::*;
#(
    parameter int BITS      = 4,
    parameter int BASE_TIME = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [idx_w(BITS)-1:0] plane,
    output logic                   done
);

    localparam int MAX_TIME = BASE_TIME << (BITS - 1);
    localparam int TW       = $clog2(MAX_TIME + 1);

    logic [TW-1:0] cnt_r;
    logic          busy_r;
    logic [TW-1:0] load_s;

    // Counting to zero makes the interval exactly BASE_TIME<<plane cycles.
    assign load_s = (TW'(BASE_TIME) << plane) - TW'(1);
    assign done   = busy_r && (cnt_r == '0);

    // Down-counter for the display interval
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r  <= '0;
            busy_r <= 1'b0;
        end else if (start) begin
            cnt_r  <= load_s;
            busy_r <= 1'b1;
        end else if (busy_r) begin
            if (cnt_r == '0) begin
                busy_r <= 1'b0;
            end else begin
                cnt_r <= cnt_r - TW'(1);
            end
        end
    end

endmodule

// File: rtl/matrix_scan_ctrl.sv
// HUB75 scan scheduler: fetches pixel words, shifts one bit-plane per pass,
// then latches, addresses and shows that plane for a binary-weighted time.
module matrix_scan_ctrl
    import matrix_pkg::*;
#(
    parameter int COLS      = 32,
    parameter int ROW_BITS  = 4,
    parameter int BITS      = 4,
    parameter int BASE_TIME = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  enable,
    output logic                                  fb_rd_en,
    output logic [fb_addr_w(ROW_BITS, COLS)-1:0]  fb_addr,
    input  logic [6*BITS-1:0]                     fb_data,
    output logic [1:0]                            mat_r,
    output logic [1:0]                            mat_g,
    output logic [1:0]                            mat_b,
    output logic [ROW_BITS-1:0]                   mat_row,
    output logic                                  mat_clk,
    output logic                                  mat_lat,
    output logic                                  mat_oe,
    output logic                                  frame_start
);

    localparam int CB = $clog2(COLS);
    localparam int PW = idx_w(BITS);
    localparam int AW = fb_addr_w(ROW_BITS, COLS);
    localparam logic [CB:0]   SHIFT_LAST = (CB+1)'(2 * COLS - 1);
    localparam logic [CB:0]   COL_LAST   = (CB+1)'(COLS - 1);
    localparam logic [PW-1:0] PLANE_LAST = PW'(BITS - 1);

    logic [2:0]          state_r, state_s;
    logic [CB:0]         shift_r, shift_s;
    logic [ROW_BITS-1:0] row_r, row_s, adv_row_s, mat_row_s;
    logic [PW-1:0]       plane_r, plane_s, adv_plane_s;
    logic                rd_d_r;
    logic                rd_s, clk_s, lat_s, oe_s, fs_s;
    logic [AW-1:0]       addr_s;
    logic [CB:0]         nxt_col_s;
    logic                timer_done_s;
    logic [BITS-1:0]     lane_s [NUM_LANES];

    matrix_bcm_timer #(
        .BITS      (BITS),
        .BASE_TIME (BASE_TIME)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .start (state_r == S_LATCH),
        .plane (plane_r),
        .done  (timer_done_s)
    );

    // Split the framebuffer word into its six colour lanes
    always_comb begin
        for (int k = 0; k < NUM_LANES; k++) begin
            lane_s[k] = fb_data[BITS*k +: BITS];
        end
    end

    // Next plane/row in scan order: planes inner, rows outer, row wraps to 0
    always_comb begin
        if (plane_r == PLANE_LAST) begin
            adv_plane_s = '0;
            adv_row_s   = row_r + ROW_BITS'(1);
        end else begin
            adv_plane_s = plane_r + PW'(1);
            adv_row_s   = row_r;
        end
    end

    assign nxt_col_s = {1'b0, shift_r[CB:1]} + (CB+1)'(1);

    // Next-state and next-output decode; every output is computed one cycle early
    always_comb begin
        state_s   = state_r;
        shift_s   = shift_r;
        row_s     = row_r;
        plane_s   = plane_r;
        rd_s      = 1'b0;
        addr_s    = fb_addr;
        clk_s     = 1'b0;
        lat_s     = 1'b0;
        oe_s      = 1'b1;
        fs_s      = 1'b0;
        mat_row_s = mat_row;
        case (state_r)
            S_IDLE: begin
                if (enable) begin
                    state_s = S_PREF0;
                    rd_s    = 1'b1;
                    addr_s  = {row_r, CB'(0)};
                    fs_s    = (row_r == '0) && (plane_r == '0);
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_PREF0: begin
                state_s = S_PREF1;
            end
            S_PREF1: begin
                state_s = S_SHIFT;
                shift_s = '0;
                rd_s    = 1'b1;
                addr_s  = {row_r, CB'(1)};
            end
            S_SHIFT: begin
                if (!shift_r[0]) begin
                    shift_s = shift_r + (CB+1)'(1);
                    clk_s   = 1'b1;
                end else if (shift_r == SHIFT_LAST) begin
                    state_s = S_BLANK;
                    shift_s = '0;
                end else begin
                    shift_s = shift_r + (CB+1)'(1);
                    // Prefetch one column ahead so the word lands during H.
                    if (nxt_col_s < COL_LAST) begin
                        rd_s   = 1'b1;
                        addr_s = {row_r, CB'(nxt_col_s + (CB+1)'(1))};
                    end else begin
                        rd_s   = 1'b0;
                    end
                end
            end
            S_BLANK: begin
                state_s   = S_LATCH;
                lat_s     = 1'b1;
                mat_row_s = row_r;
            end
            S_LATCH: begin
                state_s = S_DISPLAY;
                oe_s    = 1'b0;
            end
            S_DISPLAY: begin
                if (timer_done_s) begin
                    row_s   = adv_row_s;
                    plane_s = adv_plane_s;
                    if (enable) begin
                        state_s = S_PREF0;
                        rd_s    = 1'b1;
                        addr_s  = {adv_row_s, CB'(0)};
                        fs_s    = (adv_row_s == '0) && (adv_plane_s == '0);
                    end else begin
                        state_s = S_IDLE;
                    end
                end else begin
                    oe_s = 1'b0;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State, counters and registered panel/framebuffer outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= S_IDLE;
            shift_r     <= '0;
            row_r       <= '0;
            plane_r     <= '0;
            rd_d_r      <= 1'b0;
            fb_rd_en    <= 1'b0;
            fb_addr     <= '0;
            mat_clk     <= 1'b0;
            mat_lat     <= 1'b0;
            mat_oe      <= 1'b1;
            frame_start <= 1'b0;
            mat_row     <= '0;
            mat_r       <= 2'b00;
            mat_g       <= 2'b00;
            mat_b       <= 2'b00;
        end else begin
            state_r     <= state_s;
            shift_r     <= shift_s;
            row_r       <= row_s;
            plane_r     <= plane_s;
            rd_d_r      <= fb_rd_en;
            fb_rd_en    <= rd_s;
            fb_addr     <= addr_s;
            mat_clk     <= clk_s;
            mat_lat     <= lat_s;
            mat_oe      <= oe_s;
            frame_start <= fs_s;
            mat_row     <= mat_row_s;
            // Only words that were actually requested are captured.
            if (rd_d_r) begin
                mat_r <= {lane_s[LANE_R1][plane_r], lane_s[LANE_R0][plane_r]};
                mat_g <= {lane_s[LANE_G1][plane_r], lane_s[LANE_G0][plane_r]};
                mat_b <= {lane_s[LANE_B1][plane_r], lane_s[LANE_B0][plane_r]};
            end
        end
    end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Self-checking bench for matrix_scan_ctrl: per-cycle timeline model,
// per-pass statistics table, enable-drop and async-reset sequences.
module tb_matrix_scan_ctrl;

    localparam int COLS      = 4;
    localparam int ROW_BITS  = 4;
    localparam int BITS      = 2;
    localparam int BASE_TIME = 2;
    localparam int ROWS      = 16;
    localparam int AW        = 6;
    localparam int DW        = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          fb_rd_en;
    logic [AW-1:0] fb_addr;
    logic [DW-1:0] fb_data;
    logic [1:0]    mat_r, mat_g, mat_b;
    logic [3:0]    mat_row;
    logic          mat_clk, mat_lat, mat_oe, frame_start;

    int tests    = 0;
    int failures = 0;

    logic [DW-1:0] mem [64];
    int            m_row, m_plane, m_shown;
    logic [AW-1:0] m_addr;

    typedef struct {
        int row;
        int len;
        int clk_rises;
        int lat;
        int oe_low;
        int rd;
    } pass_stat_t;

    typedef struct {
        int row;
        int plane;
        int len;
        int clk_rises;
        int lat;
        int oe_low;
        int rd;
    } vec_t;

    pass_stat_t stats [$];
    int         fs_times [$];

    always #5 clk = ~clk;

    matrix_scan_ctrl #(
        .COLS      (COLS),
        .ROW_BITS  (ROW_BITS),
        .BITS      (BITS),
        .BASE_TIME (BASE_TIME)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .fb_rd_en    (fb_rd_en),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .mat_r       (mat_r),
        .mat_g       (mat_g),
        .mat_b       (mat_b),
        .mat_row     (mat_row),
        .mat_clk     (mat_clk),
        .mat_lat     (mat_lat),
        .mat_oe      (mat_oe),
        .frame_start (frame_start)
    );

    // Framebuffer with one-cycle read latency; garbage when not read
    always @(posedge clk) begin
        if (fb_rd_en) fb_data <= mem[fb_addr];
        else          fb_data <= DW'($urandom);
    end

    function automatic logic lane_bit(input logic [DW-1:0] w, input int lane, input int pl);
        logic [DW-1:0] t;
        t = w >> (BITS * lane + pl);
        return t[0];
    endfunction

    function automatic logic [14:0] act_ctl();
        return {fb_rd_en, fb_addr, mat_clk, mat_lat, mat_oe, frame_start, mat_row};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pass statistics, frame_start times, and row-change-while-lit check
    int         mon_cyc = 0;
    logic       in_pass = 1'b0;
    logic       prev_valid = 1'b0;
    logic [3:0] prev_row;
    logic       prev_oe, prev_clk;
    pass_stat_t cur;
    always @(negedge clk) begin
        if (!rst) begin
            in_pass    = 1'b0;
            prev_valid = 1'b0;
        end else begin
            mon_cyc++;
            if (prev_valid && (mat_row != prev_row)) begin
                check("row change while lit", 32'({prev_oe, mat_oe}), 32'(2'b11));
            end
            if (fb_rd_en && (fb_addr[1:0] == 2'd0)) begin
                if (in_pass) stats.push_back(cur);
                cur = '{row: int'(fb_addr[5:2]), len: 0, clk_rises: 0, lat: 0, oe_low: 0, rd: 0};
                in_pass = 1'b1;
            end
            if (in_pass) begin
                cur.len++;
                if (mat_clk && prev_valid && !prev_clk) cur.clk_rises++;
                if (mat_lat) cur.lat++;
                if (!mat_oe) cur.oe_low++;
                if (fb_rd_en) cur.rd++;
            end
            if (frame_start) fs_times.push_back(mon_cyc);
            prev_row   = mat_row;
            prev_oe    = mat_oe;
            prev_clk   = mat_clk;
            prev_valid = 1'b1;
        end
    end

    // Check one plane pass cycle by cycle against the expected timeline.
    task automatic check_pass(input int drop_at, input int abort_at);
        int         len;
        int         c, h;
        logic       rd_e, clk_e, lat_e, oe_e, fs_e, chk_d;
        logic [5:0] d_e;
        logic [AW-1:0] idx;
        logic [DW-1:0] w;
        len = 2 * COLS + 4 + (BASE_TIME << m_plane);
        for (int i = 0; i < len; i++) begin
            rd_e = 1'b0; clk_e = 1'b0; lat_e = 1'b0; oe_e = 1'b1; fs_e = 1'b0;
            chk_d = 1'b0; d_e = 6'd0;
            if (i == 0) begin
                rd_e   = 1'b1;
                m_addr = AW'(m_row * COLS);
                fs_e   = (m_row == 0) && (m_plane == 0);
            end else if (i == 1) begin
                rd_e = 1'b0;
            end else if (i < 2 + 2 * COLS) begin
                c = (i - 2) / 2;
                h = (i - 2) % 2;
                clk_e = (h == 1);
                if (h == 0 && c < COLS - 1) begin
                    rd_e   = 1'b1;
                    m_addr = AW'(m_row * COLS + c + 1);
                end
                idx = AW'(m_row * COLS + c);
                w   = mem[idx];
                chk_d = 1'b1;
                d_e = {lane_bit(w, 3, m_plane), lane_bit(w, 0, m_plane),
                       lane_bit(w, 4, m_plane), lane_bit(w, 1, m_plane),
                       lane_bit(w, 5, m_plane), lane_bit(w, 2, m_plane)};
            end else if (i == 2 + 2 * COLS) begin
                oe_e = 1'b1;
            end else if (i == 3 + 2 * COLS) begin
                lat_e   = 1'b1;
                m_shown = m_row;
            end else begin
                oe_e = 1'b0;
            end
            check($sformatf("r%0d p%0d cyc%0d ctl", m_row, m_plane, i), 32'(act_ctl()),
                  32'({rd_e, m_addr, clk_e, lat_e, oe_e, fs_e, 4'(m_shown)}));
            if (chk_d) begin
                check($sformatf("r%0d p%0d cyc%0d data", m_row, m_plane, i),
                      32'({mat_r, mat_g, mat_b}), 32'(d_e));
            end
            if (i == abort_at) return;
            if (i == drop_at) enable = 1'b0;
            @(negedge clk);
        end
        if (m_plane == BITS - 1) begin
            m_plane = 0;
            m_row   = (m_row + 1) % ROWS;
        end else begin
            m_plane++;
        end
    endtask

    // Parked blanked for k cycles, then enable is raised again.
    task automatic idle_phase(input int k);
        for (int j = 0; j < k; j++) begin
            check($sformatf("idle r%0d p%0d cyc%0d", m_row, m_plane, j), 32'(act_ctl()),
                  32'({1'b0, m_addr, 1'b0, 1'b0, 1'b1, 1'b0, 4'(m_shown)}));
            if (j == k - 1) enable = 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: bench did not complete within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl [6];
        int   n;
        int   len;
        int   drop;

        tbl[0] = '{row: 0, plane: 0, len: 14, clk_rises: 4, lat: 1, oe_low: 2, rd: 4};
        tbl[1] = '{row: 0, plane: 1, len: 16, clk_rises: 4, lat: 1, oe_low: 4, rd: 4};
        tbl[2] = '{row: 1, plane: 0, len: 14, clk_rises: 4, lat: 1, oe_low: 2, rd: 4};
        tbl[3] = '{row: 1, plane: 1, len: 16, clk_rises: 4, lat: 1, oe_low: 4, rd: 4};
        tbl[4] = '{row: 2, plane: 0, len: 14, clk_rises: 4, lat: 1, oe_low: 2, rd: 4};
        tbl[5] = '{row: 2, plane: 1, len: 16, clk_rises: 4, lat: 1, oe_low: 4, rd: 4};

        // Directed picture: col 2 of every row has r0=01 and b1=10.
        for (int a = 0; a < 64; a++) begin
            mem[a] = ((a % COLS) == 2) ? 12'b10_0000_0000_01 : 12'd0;
        end
        m_row = 0; m_plane = 0; m_shown = 0; m_addr = '0;

        rst = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset ctl", 32'(act_ctl()), 32'({1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0}));
        check("reset data", 32'({mat_r, mat_g, mat_b}), 32'(6'd0));
        rst = 1'b1;
        @(negedge clk);
        idle_phase(100);

        // One full frame plus the first pass of the next.
        for (int p = 0; p < 33; p++) check_pass(-1, -1);

        if (fs_times.size() >= 2) begin
            check("frame period", 32'(fs_times[1] - fs_times[0]), 32'd480);
        end else begin
            check("frame_start count", 32'(fs_times.size()), 32'd2);
        end
        if (stats.size() < 6) check("pass stat count", 32'(stats.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < stats.size()) begin
                check($sformatf("tbl%0d r%0d p%0d row", i, tbl[i].row, tbl[i].plane), 32'(stats[i].row), 32'(tbl[i].row));
                check($sformatf("tbl%0d r%0d p%0d len", i, tbl[i].row, tbl[i].plane), 32'(stats[i].len), 32'(tbl[i].len));
                check($sformatf("tbl%0d r%0d p%0d clk rises", i, tbl[i].row, tbl[i].plane), 32'(stats[i].clk_rises), 32'(tbl[i].clk_rises));
                check($sformatf("tbl%0d r%0d p%0d lat", i, tbl[i].row, tbl[i].plane), 32'(stats[i].lat), 32'(tbl[i].lat));
                check($sformatf("tbl%0d r%0d p%0d oe low", i, tbl[i].row, tbl[i].plane), 32'(stats[i].oe_low), 32'(tbl[i].oe_low));
                check($sformatf("tbl%0d r%0d p%0d reads", i, tbl[i].row, tbl[i].plane), 32'(stats[i].rd), 32'(tbl[i].rd));
            end
        end

        // Random picture with random enable drops.
        for (int a = 0; a < 64; a++) mem[a] = DW'($urandom);
        n = 0;
        while (n < 20 || !(m_row == 5 && m_plane == 0)) begin
            len  = 2 * COLS + 4 + (BASE_TIME << m_plane);
            drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            check_pass(drop, -1);
            if (!enable) idle_phase(int'($urandom_range(1, 5)));
            n++;
        end

        // Drop enable mid-SHIFT of row 5 plane 0; resume at row 5 plane 1.
        check_pass(4, -1);
        idle_phase(3);
        check("resume row", 32'(fb_addr[5:2]), 32'd5);
        check("resume read", 32'(fb_rd_en), 32'd1);
        check_pass(-1, -1);

        // Async reset in the DISPLAY phase of row 6 plane 0.
        check_pass(-1, 2 * COLS + 4);
        #2;
        rst = 1'b0;
        #1;
        check("async reset", 32'({mat_oe, mat_row, mat_lat, mat_clk, fb_rd_en, frame_start}),
              32'({1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0}));
        m_row = 0; m_plane = 0; m_shown = 0; m_addr = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int p = 0; p < 3; p++) check_pass(-1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
